// File: rtl/play_receiver.sv
// play_receiver: UART 8N1 receiver (8E1 when PLAY_RX_PARITY_EN is defined) decoding LF-terminated hex frames into `expected`.
// Latency: pronto/erro 2 cycles after the stop-bit sample; no backpressure, every received byte is consumed.
module play_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_CHARS    = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   serial_rx,
    output logic                   recebendo,
    output logic [7:0]             dado_rx,
    output logic                   pronto,
    output logic                   erro,
    output logic [4*NUM_CHARS-1:0] expected
);

    localparam int EW  = 4 * NUM_CHARS;
    localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CCW = $clog2(NUM_CHARS + 1);

    localparam logic [CW-1:0]  BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CCW-1:0] CHARS_FULL = CCW'(NUM_CHARS);

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef PLAY_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    localparam logic F_COLLECT = 1'b0;
    localparam logic F_DISCARD = 1'b1;

    logic           r_rx_meta;
    logic           r_rx_s;
    logic [2:0]     r_state;
    logic [CW-1:0]  r_clk_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shreg;
    logic           r_recebendo;
    logic [7:0]     r_dado_rx;
    logic           r_byte_ok;
    logic           r_byte_bad;

    logic           r_fstate;
    logic [CCW-1:0] r_char_cnt;
    logic [EW-1:0]  r_nib_sr;
    logic [EW-1:0]  r_expected;
    logic           r_pronto;
    logic           r_erro;

    logic           w_par_ok;
    logic           w_is_hex;
    logic [3:0]     w_nibble;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= serial_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef PLAY_RX_PARITY_EN
    logic r_par_bit;
    assign w_par_ok = ~(^r_shreg ^ r_par_bit);
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_recebendo <= 1'b0;
            r_dado_rx   <= '0;
            r_byte_ok   <= 1'b0;
            r_byte_bad  <= 1'b0;
`ifdef PLAY_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_byte_ok  <= 1'b0;
            r_byte_bad <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_DATA;
                            r_bit_idx   <= '0;
                            r_recebendo <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shreg   <= {r_rx_s, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef PLAY_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef PLAY_RX_PARITY_EN
                S_PARITY: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt   <= '0;
                        r_recebendo <= 1'b0;
                        if (!r_rx_s) begin
                            // Framing error: the line may still be low, so hold off new starts until it idles.
                            r_byte_bad <= 1'b1;
                            r_state    <= S_BREAK;
                        end else if (w_par_ok) begin
                            r_dado_rx <= r_shreg;
                            r_byte_ok <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_byte_bad <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_is_hex = 1'b0;
        w_nibble = 4'h0;
        if (r_dado_rx >= 8'h30 && r_dado_rx <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nibble = r_dado_rx[3:0];
        end else if ((r_dado_rx >= 8'h41 && r_dado_rx <= 8'h46) ||
                     (r_dado_rx >= 8'h61 && r_dado_rx <= 8'h66)) begin
            w_is_hex = 1'b1;
            w_nibble = r_dado_rx[3:0] + 4'd9;
        end
    end

    // Frame FSM reads r_dado_rx, which is updated in the same cycle byte_ok rises.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fstate   <= F_COLLECT;
            r_char_cnt <= '0;
            r_nib_sr   <= '0;
            r_expected <= '0;
            r_pronto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            r_erro   <= 1'b0;
            if (r_byte_bad) begin
                if (r_fstate == F_COLLECT) begin
                    r_erro   <= 1'b1;
                    r_fstate <= F_DISCARD;
                end
            end else if (r_byte_ok) begin
                if (r_fstate == F_DISCARD) begin
                    if (r_dado_rx == ASCII_LF) begin
                        r_char_cnt <= '0;
                        r_fstate   <= F_COLLECT;
                    end
                end else if (w_is_hex) begin
                    if (r_char_cnt < CHARS_FULL) begin
                        r_nib_sr   <= {r_nib_sr[EW-5:0], w_nibble};
                        r_char_cnt <= r_char_cnt + 1'b1;
                    end else begin
                        r_erro   <= 1'b1;
                        r_fstate <= F_DISCARD;
                    end
                end else if (r_dado_rx == ASCII_LF) begin
                    if (r_char_cnt == CHARS_FULL) begin
                        r_expected <= r_nib_sr;
                        r_pronto   <= 1'b1;
                    end else begin
                        r_erro <= 1'b1;
                    end
                    r_char_cnt <= '0;
                end else if (r_dado_rx != ASCII_CR) begin
                    r_erro   <= 1'b1;
                    r_fstate <= F_DISCARD;
                end
            end
        end
    end

    assign recebendo = r_recebendo;
    assign dado_rx   = r_dado_rx;
    assign pronto    = r_pronto;
    assign erro      = r_erro;
    assign expected  = r_expected;

endmodule

// File: tb/tb_play_receiver.sv
// Randomised UART frame stimulus against a string-level frame model; pulses are checked from a scoreboard queue.
module tb_play_receiver;

    localparam int CPB = 4;
    localparam int NC  = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        serial_rx = 1'b1;
    logic        recebendo;
    logic [7:0]  dado_rx;
    logic        pronto;
    logic        erro;
    logic [27:0] expected;

    always #5 clock = ~clock;

    play_receiver #(.CLKS_PER_BIT(CPB), .NUM_CHARS(NC)) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_rx (serial_rx),
        .recebendo (recebendo),
        .dado_rx   (dado_rx),
        .pronto    (pronto),
        .erro      (erro),
        .expected  (expected)
    );

    typedef struct packed {
        logic        is_pronto;
        logic [27:0] val;
    } ev_t;

    int n_checks = 0;
    int n_fail   = 0;

    ev_t        exp_q[$];
    logic [3:0] chars[$];
    bit         m_discard = 1'b0;
    logic [27:0] m_expected = '0;
    logic [7:0] m_last_byte = '0;
    bit         in_reset_window = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    task automatic push_ev(input logic p, input logic [27:0] v);
        ev_t e;
        e.is_pronto = p;
        e.val       = v;
        exp_q.push_back(e);
    endtask

    // Frame rules applied to whole received bytes.
    task automatic model_byte(input logic [7:0] b, input bit good);
        logic [27:0] v;
        if (!good) begin
            if (!m_discard) begin
                push_ev(1'b0, '0);
                m_discard = 1'b1;
            end
            return;
        end
        m_last_byte = b;
        if (m_discard) begin
            if (b == 8'h0A) begin
                m_discard = 1'b0;
                chars.delete();
            end
        end else if (hexval(b) >= 0) begin
            if (chars.size() < NC) chars.push_back(4'(hexval(b)));
            else begin
                push_ev(1'b0, '0);
                m_discard = 1'b1;
            end
        end else if (b == 8'h0A) begin
            if (chars.size() == NC) begin
                v = '0;
                foreach (chars[i]) v = v * 16 + 28'(chars[i]);
                m_expected = v;
                push_ev(1'b1, v);
            end else begin
                push_ev(1'b0, '0);
            end
            chars.delete();
        end else if (b != 8'h0D) begin
            push_ev(1'b0, '0);
            m_discard = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v);
        serial_rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit bad_par);
        bit good;
        good = stop_bit;
`ifdef PLAY_RX_PARITY_EN
        good = good && !bad_par;
`endif
        model_byte(b, good);
        @(negedge clock);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) check("recebendo_mid_byte", {31'd0, recebendo}, 32'd1);
            drive_bit(b[i]);
        end
`ifdef PLAY_RX_PARITY_EN
        drive_bit((^b) ^ bad_par);
`endif
        drive_bit(stop_bit);
        serial_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("dado_rx", {24'd0, dado_rx}, {24'd0, m_last_byte});
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_recebendo"}, {31'd0, recebendo}, 32'd0);
        check({tag, "_dado_rx"},   {24'd0, dado_rx},   32'd0);
        check({tag, "_pronto"},    {31'd0, pronto},    32'd0);
        check({tag, "_erro"},      {31'd0, erro},      32'd0);
        check({tag, "_expected"},  {4'd0, expected},   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        in_reset_window = 1'b1;
        serial_rx = 1'b1;
        @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b1;
        chars.delete();
        m_discard   = 1'b0;
        m_expected  = '0;
        m_last_byte = '0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        in_reset_window = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the scoreboard queue.
    ev_t         mon_e;
    logic [27:0] prev_exp;
    logic        prev_pronto = 1'b0;
    always @(negedge clock) begin
        if (reset && !in_reset_window) begin
            if (pronto || erro) begin
                check("pronto_erro_exclusive", {31'd0, pronto & erro}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: pronto=%0b erro=%0b, required none", pronto, erro);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind_pronto", {31'd0, pronto}, {31'd0, mon_e.is_pronto});
                    if (mon_e.is_pronto) check("expected_on_pronto", {4'd0, expected}, {4'd0, mon_e.val});
                end
            end
            if (pronto && prev_pronto) begin
                n_checks++;
                n_fail++;
                $display("FAIL pronto_width: high 2 cycles, required 1");
            end
            if (!pronto && expected !== prev_exp) begin
                n_checks++;
                n_fail++;
                $display("FAIL expected_stable: changed to %0h without pronto, was %0h", expected, prev_exp);
            end
        end
        prev_exp    = expected;
        prev_pronto = pronto;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        int   mode, len, pos;
        logic [7:0] c;
        int   nv;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("init");
        reset = 1'b1;
        repeat (2) @(negedge clock);
        in_reset_window = 1'b0;

        send_str("1234567\n");
        check("expected_1234567", {4'd0, expected}, {4'd0, m_expected});
        send_str("abcdefA\r\n");
        check("expected_ABCDEFA", {4'd0, expected}, 32'h0ABCDEFA);
        send_str("1234567\n");
        send_str("12G4567\n");
        check("expected_after_G", {4'd0, expected}, 32'h01234567);
        send_str("123\n");
        send_str("12345678\n");
        send_str("7654321\n");
        check("expected_7654321", {4'd0, expected}, 32'h07654321);

        send_byte("A", 1'b0, 1'b0);
        send_str("\n0000001\n");
        check("expected_0000001", {4'd0, expected}, 32'h00000001);

        // Single-cycle low glitch must not start a byte.
        @(negedge clock);
        serial_rx = 1'b0;
        @(negedge clock);
        serial_rx = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (recebendo) seen = 1'b1;
        end
        check("glitch_no_recebendo", {31'd0, seen}, 32'd0);

        // Reset in the middle of a frame and of a byte.
        send_str("89AB");
        @(negedge clock);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        do_reset();
        send_str("89ABCDE\n");
        check("expected_89ABCDE", {4'd0, expected}, 32'h089ABCDE);

`ifdef PLAY_RX_PARITY_EN
        send_byte("5", 1'b1, 1'b1);
        send_str("\n1122334\n");
        check("expected_after_parity", {4'd0, expected}, 32'h01122334);
`endif

        for (int r = 0; r < 24; r++) begin
            mode = $urandom_range(0, 5);
            len  = (mode == 2) ? $urandom_range(1, 9) : NC;
            pos  = $urandom_range(0, len - 1);
            for (int i = 0; i < len; i++) begin
                if (mode == 0 && i == pos) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                if (mode == 1 && i == pos) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
                nv = $urandom_range(0, 15);
                if (nv < 10) c = 8'(48 + nv);
                else if ($urandom_range(0, 1) == 1) c = 8'(55 + nv);
                else c = 8'(87 + nv);
                send_byte(c, 1'b1, 1'b0);
            end
            if (mode == 3) send_byte(8'h0D, 1'b1, 1'b0);
            send_byte(8'h0A, 1'b1, 1'b0);
            check("expected_random", {4'd0, expected}, {4'd0, m_expected});
        end

        repeat (20) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d still queued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
